// File: rtl/fetch_entry_queue.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_entry_queue
//  Description : Circular FIFO between frontend fetch and decode. Presents one
//                entry per cycle under valid/ready, freezes intake after an
//                entry carrying a fetch exception, and clears on flush.
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_entry_queue #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned VLEN  = 64,
    parameter int unsigned CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             flush_i,
    input  logic             push_valid_i,
    output logic             push_ready_o,
    input  logic [31:0]      push_instr_i,
    input  logic [VLEN-1:0]  push_addr_i,
    input  logic             push_ex_valid_i,
    input  logic [63:0]      push_ex_cause_i,
    input  logic             push_bp_taken_i,
    input  logic [VLEN-1:0]  push_bp_target_i,
    output logic             pop_valid_o,
    input  logic             pop_ready_i,
    output logic [31:0]      pop_instr_o,
    output logic [VLEN-1:0]  pop_addr_o,
    output logic             pop_ex_valid_o,
    output logic [63:0]      pop_ex_cause_o,
    output logic             pop_bp_taken_o,
    output logic [VLEN-1:0]  pop_bp_target_o,
    output logic [CNT_W-1:0] count_o,
    output logic             almost_full_o
);

    localparam int unsigned      PTR_W      = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] C_FULL     = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] C_ALMOST   = CNT_W'(DEPTH - 1);
    localparam logic [PTR_W-1:0] C_PTR_ONE  = PTR_W'(1);
    localparam logic [CNT_W-1:0] C_CNT_ONE  = CNT_W'(1);

    typedef struct packed {
        logic [31:0]     instr;
        logic [VLEN-1:0] addr;
        logic            ex_valid;
        logic [63:0]     ex_cause;
        logic            bp_taken;
        logic [VLEN-1:0] bp_target;
    } entry_t;

    entry_t            mem_q [DEPTH];
    entry_t            w_wdata;
    entry_t            w_head;
    logic [PTR_W-1:0]  rd_q, rd_d;
    logic [PTR_W-1:0]  wr_q, wr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              freeze_q, freeze_d;
    logic              w_push;
    logic              w_pop;

    assign w_wdata = '{instr:     push_instr_i,
                       addr:      push_addr_i,
                       ex_valid:  push_ex_valid_i,
                       ex_cause:  push_ex_cause_i,
                       bp_taken:  push_bp_taken_i,
                       bp_target: push_bp_target_i};

    // Ready/valid come from registered state only, so no input reaches them.
    assign push_ready_o  = (count_q != C_FULL) && !freeze_q;
    assign pop_valid_o   = (count_q != '0);
    assign count_o       = count_q;
    assign almost_full_o = (count_q >= C_ALMOST);

    // A flush cancels any handshake happening in the same cycle.
    assign w_push = push_valid_i && push_ready_o && !flush_i;
    assign w_pop  = pop_valid_o && pop_ready_i && !flush_i;

    assign w_head          = mem_q[rd_q];
    assign pop_instr_o     = w_head.instr;
    assign pop_addr_o      = w_head.addr;
    assign pop_ex_valid_o  = w_head.ex_valid;
    assign pop_ex_cause_o  = w_head.ex_cause;
    assign pop_bp_taken_o  = w_head.bp_taken;
    assign pop_bp_target_o = w_head.bp_target;

    // Next-state for pointers, occupancy and the exception freeze.
    always_comb begin
        rd_d     = rd_q;
        wr_d     = wr_q;
        count_d  = count_q;
        freeze_d = freeze_q;
        if (flush_i) begin
            rd_d     = '0;
            wr_d     = '0;
            count_d  = '0;
            freeze_d = 1'b0;
        end else begin
            if (w_push) begin
                wr_d = wr_q + C_PTR_ONE;
                if (push_ex_valid_i) begin
                    freeze_d = 1'b1;
                end
            end
            if (w_pop) begin
                rd_d = rd_q + C_PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   count_d = count_q + C_CNT_ONE;
                2'b01:   count_d = count_q - C_CNT_ONE;
                default: count_d = count_q;
            endcase
        end
    end

    // Control state register with asynchronous active-low reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_q     <= '0;
            wr_q     <= '0;
            count_q  <= '0;
            freeze_q <= 1'b0;
        end else begin
            rd_q     <= rd_d;
            wr_q     <= wr_d;
            count_q  <= count_d;
            freeze_q <= freeze_d;
        end
    end

    // Payload storage is left unreset; it is only observed while valid.
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            mem_q[wr_q] <= w_wdata;
        end
    end

endmodule
`default_nettype wire

// File: doc/fetch_entry_queue.md
Name: fetch_entry_queue

Overview:
- Circular FIFO between the frontend fetch path and the instruction decode stage.
- Decouples fetch bandwidth from decode back-pressure and presents one fetch entry per cycle to decode under a valid/ready handshake.
- Freezes intake after accepting an entry carrying a fetch exception, so no younger instruction is buffered behind a trapping one.
- Clears completely on a pipeline flush.

Parameters:
- DEPTH, 4, number of entries; power of two, minimum 2.
- VLEN, 64, virtual address width.
- CNT_W, $clog2(DEPTH)+1, occupancy counter width (derived).

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- flush_i  in  1  discard all entries and release the exception freeze
- push_valid_i  in  1  frontend presents an entry
- push_ready_o  out  1  queue accepts the presented entry this cycle
- push_instr_i  in  32  raw instruction bits (compressed instructions in [15:0])
- push_addr_i  in  VLEN  instruction PC
- push_ex_valid_i  in  1  fetch exception attached to the entry
- push_ex_cause_i  in  64  exception cause
- push_bp_taken_i  in  1  branch predicted taken
- push_bp_target_i  in  VLEN  predicted target
- pop_valid_o  out  1  head entry valid towards decode
- pop_ready_i  in  1  decode accepts the head entry
- pop_instr_o  out  32  head instruction
- pop_addr_o  out  VLEN  head PC
- pop_ex_valid_o  out  1  head exception flag
- pop_ex_cause_o  out  64  head exception cause
- pop_bp_taken_o  out  1  head prediction taken
- pop_bp_target_o  out  VLEN  head predicted target
- count_o  out  CNT_W  current occupancy
- almost_full_o  out  1  count_o >= DEPTH-1

Behaviour:
- Reset:
  - rst_ni is asynchronous and active-low; clk_i is the clock.
  - Pointers, count and the freeze flag reset to 0.
  - pop_valid_o=0, count_o=0, almost_full_o=0, push_ready_o=1.
  - Payload storage is not reset; pop_* payload is don't-care while pop_valid_o=0.
- State:
  - Read pointer rd_q, write pointer wr_q (log2(DEPTH) bits, natural wrap DEPTH-1 -> 0), count_q, freeze_q.
- Ready and valid:
  - push_ready_o = (count_q != DEPTH) && !freeze_q. Combinational from state only; it never depends on pop_ready_i. There is no bypass when full.
  - pop_valid_o = (count_q != 0). The pop_* payload is driven combinationally from entry[rd_q].
- Push (push_valid_i && push_ready_o && !flush_i):
  - Write entry[wr_q] and increment wr_q.
  - If push_ex_valid_i, set freeze_q next cycle.
- Pop (pop_valid_o && pop_ready_i && !flush_i):
  - Increment rd_q.
- Count:
  - count_q += push - pop. A simultaneous push and pop leaves the count unchanged.
- Latency:
  - Into an empty queue, an entry pushed in cycle N is visible at pop_* in cycle N+1. There is no same-cycle fall-through.
- Flush:
  - On flush_i, next cycle rd_q=wr_q=0, count_q=0 and freeze_q=0.
  - A push or pop in the flush cycle has no effect on state, even if handshake signals were high.
  - push_ready_o is still computed as normal in the flush cycle; the frontend must treat its own flush as cancelling the transfer.
- Freeze:
  - While freeze_q=1, push_ready_o=0 regardless of occupancy.
  - Popping the exception entry does not clear the freeze; only flush_i or reset does.
- Outputs:
  - count_o = count_q.
  - almost_full_o is derived from count_q (registered state, no input-to-output path).
- Payload:
  - Data is stored and returned unmodified, with no reordering.
- Reset mid-operation:
  - Asynchronous reset immediately returns all outputs to their reset values.

Test Plan:
- Fill/drain: hold pop_ready_i=0 and push 4 entries with PCs 0x1000, 0x1004, 0x1008, 0x100C.
  - After the 3rd push, almost_full_o=1; after the 4th, push_ready_o=0 and count_o=4.
  - Then set pop_ready_i=1: PCs pop in order over 4 cycles, ending with count_o=0 and pop_valid_o=0.
- Simultaneous push+pop at count 2 for 8 cycles:
  - count_o stays 2; pointers wrap past 3 -> 0 with data intact.
  - Instr values 0x00000013+k appear in push order.
- Full and pop same cycle: with count=4 and push_valid_i=1, pop one entry.
  - push_ready_o=0 in that cycle.
  - Next cycle count_o=3 and push_ready_o=1.
- Exception freeze: push PC 0x2000 with ex_valid=1, cause 12.
  - Next cycle push_ready_o=0 with count 1.
  - Drain it: pop_ex_valid_o=1, cause 12; push_ready_o stays 0.
  - Assert flush_i: next cycle push_ready_o=1.
- Flush with concurrent handshakes: at count 3, assert flush_i together with push_valid_i=1 and pop_ready_i=1.
  - Next cycle count_o=0, pop_valid_o=0, and the pushed entry is absent.
- Async reset mid-stream: drop rst_ni at count 2.
  - Outputs immediately go to pop_valid_o=0, count_o=0, push_ready_o=1.
  - After reset is released, the first push appears at the head one cycle later.
